// File: rtl/multi_edge_tracer.sv
// multi_edge_tracer: per-channel synchroniser, debouncer and edge-pulse
// generator with sticky event flags and a registered any-pulse summary.
module multi_edge_tracer #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   noisy_in,
    input  logic [2*CHANNELS-1:0] edge_sel,
    input  logic                  en,
    input  logic [CHANNELS-1:0]   clr_sticky,
    output logic [CHANNELS-1:0]   level_out,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic [CHANNELS-1:0]   sticky_out,
    output logic                  any_pulse
);

    // Counter width is derived so it always holds DEBOUNCE_CYCLES-1.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_chain [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_q;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] qualify;

    assign sync_q = sync_chain[SYNC_STAGES-1];

    // Plain flop chain per channel; nothing sits between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= '0;
            end
        end else begin
            sync_chain[0] <= noisy_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= sync_chain[s-1];
            end
        end
    end

    // A new level is accepted once it has differed for DEBOUNCE_CYCLES samples;
    // the new level itself tells rise (1) from fall (0) for mode matching.
    always_comb begin
        accept  = '0;
        qualify = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i]  = (sync_q[i] != level_out[i]) && (cnt[i] == CNT_LAST);
            qualify[i] = accept[i] && en &&
                         (sync_q[i] ? edge_sel[2*i] : edge_sel[2*i+1]);
        end
    end

    // Stability counters restart whenever the sample agrees or a level is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ((sync_q[i] == level_out[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Level, pulse and sticky all update on the accepting edge; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_out  <= '0;
            pulse_out  <= '0;
            sticky_out <= '0;
        end else begin
            level_out  <= level_out ^ accept;
            pulse_out  <= qualify;
            sticky_out <= qualify | (sticky_out & ~clr_sticky);
        end
    end

    // Summary flag trails pulse_out by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pulse <= 1'b0;
        end else begin
            any_pulse <= |pulse_out;
        end
    end

endmodule

// File: tb/tb_multi_edge_tracer.sv
// Bench for multi_edge_tracer: directed scenarios plus random traffic, all
// cycles compared against a sample-history reference model.
module tb_multi_edge_tracer;

    localparam int CH   = 4;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int MAXC = 4096;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic [CH-1:0] noisy_in   = '0;
    logic [2*CH-1:0] edge_sel = '0;
    logic          en         = 1'b0;
    logic [CH-1:0] clr_sticky = '0;
    logic [CH-1:0] level_out;
    logic [CH-1:0] pulse_out;
    logic [CH-1:0] sticky_out;
    logic          any_pulse;

    multi_edge_tracer #(
        .CHANNELS(CH),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .noisy_in(noisy_in),
        .edge_sel(edge_sel),
        .en(en),
        .clr_sticky(clr_sticky),
        .level_out(level_out),
        .pulse_out(pulse_out),
        .sticky_out(sticky_out),
        .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remembers every raw input sample by cycle number.
    // The debouncer at edge t sees the raw sample taken S edges earlier; a
    // level is accepted when the last D seen samples all differ from the
    // current level and none of them predates the previous acceptance.
    int cyc  = 0;
    int base = 0;
    bit nz [CH][MAXC];
    int last_acc [CH];
    logic [CH-1:0] m_level  = '0;
    logic [CH-1:0] m_pulse  = '0;
    logic [CH-1:0] m_sticky = '0;
    logic          m_any    = 1'b0;
    logic [CH-1:0] np;
    bit            acc;
    logic [1:0]    mode;

    function automatic bit seen(input int c, input int t);
        if ((t - S) < base) return 1'b0;
        return nz[c][t-S];
    endfunction

    always @(negedge rst_n) begin
        m_level  = '0;
        m_pulse  = '0;
        m_sticky = '0;
        m_any    = 1'b0;
        for (int c = 0; c < CH; c++) last_acc[c] = -1000;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            base = cyc + 1;
        end else begin
            np = '0;
            for (int c = 0; c < CH; c++) begin
                nz[c][cyc] = noisy_in[c];
                acc = ((cyc - last_acc[c]) >= D);
                for (int k = 0; k < D; k++) begin
                    if (seen(c, cyc - k) == m_level[c]) acc = 1'b0;
                end
                if (acc) begin
                    last_acc[c] = cyc;
                    mode = edge_sel[2*c +: 2];
                    np[c] = en && (m_level[c] ? mode[1] : mode[0]);
                    m_level[c] = ~m_level[c];
                end
                if (np[c]) m_sticky[c] = 1'b1;
                else if (clr_sticky[c]) m_sticky[c] = 1'b0;
            end
            m_any   = |m_pulse;
            m_pulse = np;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("level", 32'(level_out), 32'(m_level));
        check("pulse", 32'(pulse_out), 32'(m_pulse));
        check("sticky", 32'(sticky_out), 32'(m_sticky));
        check("any", 32'(any_pulse), 32'(m_any));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"}, 32'(level_out), 32'd0);
        check({tag, "_pulse"}, 32'(pulse_out), 32'd0);
        check({tag, "_sticky"}, 32'(sticky_out), 32'd0);
        check({tag, "_any"}, 32'(any_pulse), 32'd0);
    endtask

    initial begin
        int cnt_p;
        int first_p;
        int second_p;
        bit seen_hi;

        for (int c = 0; c < CH; c++) last_acc[c] = -1000;
        repeat (3) step();
        check_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;

        // Rise on ch0: level and pulse exactly five edges after sampling.
        edge_sel = 8'b0000_0001;
        repeat (2) step();
        noisy_in[0] = 1'b1;
        repeat (5) step();
        check("t1_pre_level", 32'(level_out[0]), 32'd0);
        step();
        check("t1_level", 32'(level_out[0]), 32'd1);
        check("t1_pulse", 32'(pulse_out), 32'h1);
        check("t1_sticky", 32'(sticky_out[0]), 32'd1);
        check("t1_any_early", 32'(any_pulse), 32'd0);
        step();
        check("t1_pulse_off", 32'(pulse_out), 32'h0);
        check("t1_any", 32'(any_pulse), 32'd1);
        step();
        check("t1_any_off", 32'(any_pulse), 32'd0);

        // Glitch of three cycles on ch0 is rejected.
        noisy_in[0] = 1'b0;
        repeat (8) step();
        clr_sticky = 4'b0001;
        step();
        clr_sticky = '0;
        noisy_in[0] = 1'b1;
        seen_hi = 1'b0;
        repeat (3) begin
            step();
            seen_hi |= level_out[0] | pulse_out[0];
        end
        noisy_in[0] = 1'b0;
        repeat (8) begin
            step();
            seen_hi |= level_out[0] | pulse_out[0];
        end
        check("t2_glitch_seen", 32'(seen_hi), 32'd0);
        check("t2_sticky", 32'(sticky_out[0]), 32'd0);

        // Both-edge mode on ch1: two pulses ten cycles apart.
        edge_sel = 8'b0000_1100;
        cnt_p = 0; first_p = -1; second_p = -1;
        for (int i = 0; i < 30; i++) begin
            noisy_in[1] = (i < 10);
            step();
            if (pulse_out[1]) begin
                cnt_p++;
                if (first_p < 0) first_p = i; else second_p = i;
            end
        end
        check("t3_both_count", 32'(cnt_p), 32'd2);
        check("t3_both_gap", 32'(second_p - first_p), 32'd10);
        edge_sel = 8'b0000_1000;
        cnt_p = 0; second_p = -1;
        for (int i = 0; i < 30; i++) begin
            noisy_in[1] = (i < 10);
            step();
            if (pulse_out[1]) begin
                cnt_p++;
                second_p = i;
            end
        end
        check("t3_fall_count", 32'(cnt_p), 32'd1);
        check("t3_fall_at", 32'(second_p), 32'd15);

        // Rise on ch2 with en low is dropped and never replayed.
        edge_sel = 8'b0001_0000;
        en = 1'b0;
        noisy_in[2] = 1'b1;
        cnt_p = 0;
        repeat (8) begin
            step();
            cnt_p += int'(pulse_out[2]);
        end
        check("t4_level", 32'(level_out[2]), 32'd1);
        check("t4_sticky", 32'(sticky_out[2]), 32'd0);
        en = 1'b1;
        repeat (6) begin
            step();
            cnt_p += int'(pulse_out[2]);
        end
        check("t4_pulses", 32'(cnt_p), 32'd0);

        // Sticky set wins over a simultaneous clear on ch3.
        edge_sel = 8'b0100_0000;
        noisy_in[3] = 1'b1;
        repeat (5) step();
        clr_sticky = 4'b1000;
        step();
        check("t5_pulse", 32'(pulse_out[3]), 32'd1);
        check("t5_sticky_set", 32'(sticky_out[3]), 32'd1);
        step();
        check("t5_sticky_clr", 32'(sticky_out[3]), 32'd0);
        clr_sticky = '0;

        // All channels rise, reset mid-debounce, then re-accept after release.
        edge_sel = 8'hFF;
        noisy_in = '0;
        repeat (8) step();
        noisy_in = 4'hF;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("t6_pre_level", 32'(level_out), 32'h0);
        step();
        check("t6_level", 32'(level_out), 32'hF);
        check("t6_pulse", 32'(pulse_out), 32'hF);
        step();
        check("t6_any", 32'(any_pulse), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(5) == 0) noisy_in[c] = ~noisy_in[c];
            end
            if ($urandom_range(30) == 0) edge_sel = 8'($urandom);
            en = ($urandom_range(7) != 0);
            clr_sticky = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(399) == 0) begin
                rst_n = 1'b0;
                #1;
                check_zero("rnd_async");
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
